// File: rtl/clue_rom_arbiter.sv
// Round-robin burst arbiter sharing one registered-read clue ROM between NUM_REQ requesters.
// Each grant streams len consecutive words back to its owner, tagged with owner id and word index.
module clue_rom_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 20,
  parameter int ROM_LATENCY = 2,
  parameter int LEN_W       = 6
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_in,
  output logic [NUM_REQ-1:0]        grant_out,
  output logic [ADDR_W-1:0]         rom_addr_out,
  input  logic [DATA_W-1:0]         rom_data_in,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid_out,
  output logic [1:0]                data_id_out,
  output logic [LEN_W-1:0]          data_index_out,
  output logic [NUM_REQ-1:0]        done_out,
  output logic                      busy_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                            state_q, state_d;
  logic [1:0]                        rr_q, rr_d;
  logic [1:0]                        owner_q, owner_d;
  logic [LEN_W-1:0]                  len_q, len_d;
  logic [LEN_W-1:0]                  k_q, k_d;
  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic [NUM_REQ-1:0]                grant_q, grant_d;
  logic [NUM_REQ-1:0]                done_q, done_d;
  logic [ROM_LATENCY-1:0]            sr_valid_q, sr_valid_d;
  logic [ROM_LATENCY-1:0][LEN_W-1:0] sr_idx_q, sr_idx_d;
  logic [DATA_W-1:0]                 hold_data_q, hold_data_d;
  logic [LEN_W-1:0]                  hold_idx_q, hold_idx_d;
  logic [1:0]                        hold_id_q, hold_id_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic                 arb_found;
  logic [1:0]           arb_win;
  logic [ADDR_W-1:0]    win_addr;
  logic [LEN_W-1:0]     win_len;
  logic                 pop_valid;
  logic [LEN_W-1:0]     pop_idx;
  logic [LEN_W-1:0]     len_last;

  assign req_dbl   = {req_in, req_in} >> rr_q;
  assign pop_valid = sr_valid_q[ROM_LATENCY-1];
  assign pop_idx   = sr_idx_q[ROM_LATENCY-1];
  assign len_last  = len_q - LEN_W'(1);

  // Rotating the request vector by the rr pointer turns the wrap-around search into a plain priority pick.
  always_comb begin
    int cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_win   = '0;
    win_addr  = '0;
    win_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!arb_found && req_dbl[i]) begin
        arb_found = 1'b1;
        arb_win   = 2'(cand);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_win == 2'(j)) begin
        win_addr = req_addr_in[j*ADDR_W +: ADDR_W];
        win_len  = req_len_in[j*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    len_d       = len_q;
    k_d         = k_q;
    addr_d      = addr_q;
    grant_d     = grant_q;
    done_d      = '0;
    hold_data_d = hold_data_q;
    hold_idx_d  = hold_idx_q;
    hold_id_d   = hold_id_q;
    sr_valid_d  = '0;
    sr_idx_d    = '0;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      sr_valid_d[i] = sr_valid_q[i-1];
      sr_idx_d[i]   = sr_idx_q[i-1];
    end
    if (pop_valid) begin
      hold_data_d = rom_data_in;
      hold_idx_d  = pop_idx;
      hold_id_d   = owner_q;
    end

    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          owner_d = arb_win;
          len_d   = win_len;
          k_d     = '0;
          grant_d = NUM_REQ'(1) << arb_win;
          rr_d    = (arb_win == 2'(NUM_REQ-1)) ? 2'd0 : arb_win + 2'd1;
          if (win_len == '0) begin
            done_d  = NUM_REQ'(1) << arb_win;
            state_d = DONE;
          end else begin
            addr_d  = win_addr;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        sr_valid_d[0] = 1'b1;
        sr_idx_d[0]   = k_q;
        if (k_q == len_last) begin
          state_d = DRAIN;
        end else begin
          k_d    = k_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      // Words return in order, so the last index leaving the pipe means the pipe is now empty.
      DRAIN: begin
        if (pop_valid && pop_idx == len_last) begin
          done_d  = grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      len_q       <= '0;
      k_q         <= '0;
      addr_q      <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      sr_valid_q  <= '0;
      sr_idx_q    <= '0;
      hold_data_q <= '0;
      hold_idx_q  <= '0;
      hold_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      len_q       <= len_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      sr_valid_q  <= sr_valid_d;
      sr_idx_q    <= sr_idx_d;
      hold_data_q <= hold_data_d;
      hold_idx_q  <= hold_idx_d;
      hold_id_q   <= hold_id_d;
    end
  end

  // Return data passes straight through from the ROM in its valid cycle; otherwise the last word is held.
  assign data_valid_out = pop_valid;
  assign data_out       = pop_valid ? rom_data_in : hold_data_q;
  assign data_index_out = pop_valid ? pop_idx : hold_idx_q;
  assign data_id_out    = pop_valid ? owner_q : hold_id_q;
  assign grant_out      = grant_q;
  assign rom_addr_out   = addr_q;
  assign done_out       = done_q;
  assign busy_out       = (state_q != IDLE);

endmodule
